// File: rtl/uart_tx_serializer_if.sv
// Byte-in / serial-out handshake between the word-to-byte shifter and the UART transmitter.
// master = upstream shifter side, slave = uart_tx_serializer.
interface uart_tx_serializer_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       uart_tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  uart_tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output uart_tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: one byte per tx_start, serialized LSB first as 8N1 (8E1 when
// UART_TX_PARITY_EN is defined); all outputs registered, tx_done pulses in the last stop cycle.
module uart_tx_serializer #(
    parameter int unsigned BAUD_DIV = 434,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_serializer_if.slave  tx_if
);

    // state  | meaning
    // IDLE   | line high, waiting for tx_start
    // LOAD   | capture tx_data (one cycle after acceptance)
    // START  | start bit, line low
    // DATA   | eight data bits, LSB first
    // PARITY | even parity bit (UART_TX_PARITY_EN only)
    // STOP   | stop bit, line high; tx_done in its last cycle
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q,  bit_idx_d;
    logic [7:0]       shreg_q,    shreg_d;
    logic             uart_tx_q,  uart_tx_d;
    logic             tx_busy_q,  tx_busy_d;
    logic             tx_done_q,  tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q,   parity_d;
`endif

    logic bit_last;
    assign bit_last = (baud_cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            uart_tx_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            uart_tx_q  <= uart_tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                if (tx_if.tx_start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shreg_d    = tx_if.tx_data;
                baud_cnt_d = '0;
                bit_idx_d  = '0;
`ifdef UART_TX_PARITY_EN
                parity_d   = ^tx_if.tx_data;
`endif
                state_d    = S_START;
            end
            S_START: begin
                if (bit_last) begin
                    baud_cnt_d = '0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_last) begin
                    baud_cnt_d = '0;
                    shreg_d    = {1'b0, shreg_q[7:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_last) begin
                    baud_cnt_d = '0;
                    state_d    = S_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_last) begin
                    baud_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                baud_cnt_d = '0;
                bit_idx_d  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in the same cycle as the state itself.
    always_comb begin
        uart_tx_d = 1'b1;
        tx_busy_d = 1'b0;
        tx_done_d = 1'b0;

        case (state_d)
            S_LOAD: begin
                tx_busy_d = 1'b1;
            end
            S_START: begin
                uart_tx_d = 1'b0;
                tx_busy_d = 1'b1;
            end
            S_DATA: begin
                uart_tx_d = shreg_d[0];
                tx_busy_d = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                uart_tx_d = parity_d;
                tx_busy_d = 1'b1;
            end
`endif
            S_STOP: begin
                tx_busy_d = 1'b1;
                tx_done_d = (baud_cnt_d == CNT_LAST);
            end
            default: begin
                uart_tx_d = 1'b1;
            end
        endcase
    end

    assign tx_if.uart_tx = uart_tx_q;
    assign tx_if.tx_busy = tx_busy_q;
    assign tx_if.tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer (BAUD_DIV=4); follows UART_TX_PARITY_EN when defined.
module tb_uart_tx_serializer;

    localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_serializer_if u_if ();

    uart_tx_serializer #(.BAUD_DIV(BAUD), .CNT_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .tx_if (u_if.slave)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    int         last_end = 0;
    bit         mon_en   = 1'b0;
    bit         gap_chk  = 1'b0;
    logic [7:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (u_if.tx_done === 1'b1) done_cnt <= done_cnt + 1;

    // Frame monitor: pops the expected byte at the start bit and checks every cycle of the frame.
    initial begin : monitor
        logic [7:0]       exp_b;
        logic [NBITS-1:0] bits;
        forever begin
            @(negedge clk);
            if (mon_en && rst && u_if.uart_tx === 1'b0) begin
                if (gap_chk) check("frame_gap", cyc - last_end, 3);
                if (sb.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    exp_b = 8'h00;
                end else begin
                    exp_b = sb.pop_front();
                end
                bits = '1;
                bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) bits[i+1] = exp_b[i];
`ifdef UART_TX_PARITY_EN
                bits[9] = ^exp_b;
`endif
                for (int b = 0; b < NBITS; b++) begin
                    for (int c = 0; c < BAUD; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        check("line", u_if.uart_tx, bits[b]);
                        check("busy", u_if.tx_busy, 1);
                        check("done", u_if.tx_done, (b == NBITS-1 && c == BAUD-1) ? 1 : 0);
                    end
                end
                last_end = cyc;
                @(negedge clk);
                check("done_clear", u_if.tx_done, 0);
                check("busy_clear", u_if.tx_busy, 0);
                check("idle_line", u_if.uart_tx, 1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit late, input bit expect_frame);
        if (expect_frame) sb.push_back(d);
        @(negedge clk);
        u_if.tx_start = 1'b1;
        u_if.tx_data  = late ? 8'h00 : d;
        @(negedge clk);
        u_if.tx_start = 1'b0;
        u_if.tx_data  = d;
        check("load_busy", u_if.tx_busy, 1);
        check("load_line", u_if.uart_tx, 1);
        @(negedge clk);
        u_if.tx_data  = ~d;
        check("start_latency", u_if.uart_tx, 0);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (u_if.tx_done === 1'b1) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_done;
        u_if.tx_start = 1'b0;
        u_if.tx_data  = 8'h00;
        exp_done      = 0;

        repeat (3) @(negedge clk);
        check("rst_line", u_if.uart_tx, 1);
        check("rst_busy", u_if.tx_busy, 0);
        check("rst_done", u_if.tx_done, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset mid-DATA of 0xA5: cycle 10 of the frame carries data bit 1 (0).
        send_byte(8'hA5, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        check("pre_rst_line", u_if.uart_tx, 0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_line", u_if.uart_tx, 1);
        check("async_rst_busy", u_if.tx_busy, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        check("no_done_after_rst", done_cnt, 0);
        check("rst_idle_line", u_if.uart_tx, 1);

        mon_en = 1'b1;

        send_byte(8'h55, 1'b0, 1'b1);
        wait_done();
        exp_done++;
        repeat (5) @(negedge clk);

        send_byte(8'hC3, 1'b1, 1'b1);
        wait_done();
        exp_done++;
        repeat (5) @(negedge clk);

        send_byte(8'h3C, 1'b0, 1'b1);
        repeat (15) @(negedge clk);
        u_if.tx_start = 1'b1;
        u_if.tx_data  = 8'hFF;
        @(negedge clk);
        u_if.tx_start = 1'b0;
        wait_done();
        exp_done++;
        repeat (60) @(negedge clk);

        gap_chk = 1'b0;
        send_byte(8'hDE, 1'b0, 1'b1);
        wait_done();
        exp_done++;
        gap_chk = 1'b1;
        send_byte(8'hAD, 1'b0, 1'b1);
        wait_done();
        exp_done++;
        send_byte(8'hBE, 1'b0, 1'b1);
        wait_done();
        exp_done++;
        send_byte(8'hEF, 1'b0, 1'b1);
        wait_done();
        exp_done++;
        gap_chk = 1'b0;

        // tx_start during the tx_done cycle is still in STOP and must be dropped.
        u_if.tx_start = 1'b1;
        u_if.tx_data  = 8'h99;
        @(negedge clk);
        u_if.tx_start = 1'b0;
        repeat (60) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        send_byte(8'h07, 1'b0, 1'b1);
        wait_done();
        exp_done++;
        repeat (5) @(negedge clk);
        send_byte(8'h03, 1'b0, 1'b1);
        wait_done();
        exp_done++;
        repeat (5) @(negedge clk);
`endif

        check("done_pulses", done_cnt, exp_done);
        check("sb_empty", sb.size(), 0);
        check("final_idle", u_if.uart_tx, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
